// File: rtl/timer_controller.sv
// timer_controller
//   Programmable interval timer. A prescaler down-counter divides clk into
//   base ticks. An interval counter then counts base ticks down from a loaded
//   reload value. On completion it emits a single-cycle expire pulse, either
//   once (one-shot) or repeatedly (periodic). The timer supports
//   load/start/stop/hold control.
//
// Parameters
//   PRESCALE  clk cycles per base tick (>= 1)
//   WIDTH     interval counter width (1..32)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   load_valid  load request
//   load_ready  load accepted when high together with load_valid (IDLE/DONE)
//   load_count  interval length in base ticks
//   load_mode   0 = one-shot, 1 = periodic
//   start       start request
//   stop        abort request
//   hold        level; freezes timing while high
//   expire      one-cycle pulse on interval completion
//   busy        high in RUN or HOLD
//   remaining   current interval count
//   state       IDLE=00, RUN=01, HOLD=10, DONE=11
//
// State table
//   state | meaning
//   IDLE  | loaded or stopped, waiting for start (load accepted)
//   RUN   | prescaler and interval counter advancing
//   HOLD  | timing frozen while hold is high
//   DONE  | one-shot interval finished (load or restart accepted)
module timer_controller #(
  parameter int PRESCALE = 1000,
  parameter int WIDTH    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_count,
  input  logic             load_mode,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic             expire,
  output logic             busy,
  output logic [WIDTH-1:0] remaining,
  output logic [1:0]       state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_INIT = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             expire_q, expire_d;
  logic             busy_q, busy_d;
  logic             tick;

  assign tick = (pre_q == '0);

  always_comb begin
    state_d     = state_q;
    reload_d    = reload_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    pre_d       = pre_q;
    expire_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A load beats a coincident start: load_ready high means accepted.
        if (load_valid) begin
          reload_d    = load_count;
          mode_d      = load_mode;
          remaining_d = load_count;
        end else if (start && (reload_q != '0)) begin
          state_d = S_RUN;
          pre_d   = PRE_INIT;
        end
      end
      S_DONE: begin
        if (load_valid) begin
          reload_d    = load_count;
          mode_d      = load_mode;
          remaining_d = load_count;
          state_d     = S_IDLE;
        end else if (start && (reload_q != '0)) begin
          remaining_d = reload_q;
          pre_d       = PRE_INIT;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d     = S_IDLE;
          remaining_d = reload_q;
          pre_d       = PRE_INIT;
        end else if (hold) begin
          // The entry cycle still counts the prescaler down, but a tick is
          // never taken here; a pending tick waits for the next RUN cycle.
          state_d = S_HOLD;
          if (!tick) pre_d = pre_q - 1'b1;
        end else if (tick) begin
          pre_d = PRE_INIT;
          if (remaining_q > WIDTH'(1)) begin
            remaining_d = remaining_q - 1'b1;
          end else begin
            expire_d = 1'b1;
            if (mode_q) begin
              remaining_d = reload_q;
            end else begin
              remaining_d = '0;
              state_d     = S_DONE;
            end
          end
        end else begin
          pre_d = pre_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d     = S_IDLE;
          remaining_d = reload_q;
          pre_d       = PRE_INIT;
        end else if (!hold) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      reload_q    <= '0;
      mode_q      <= 1'b0;
      remaining_q <= '0;
      pre_q       <= PRE_INIT;
      expire_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      pre_q       <= pre_d;
      expire_q    <= expire_d;
      busy_q      <= busy_d;
    end
  end

  assign load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign expire     = expire_q;
  assign busy       = busy_q;
  assign remaining  = remaining_q;
  assign state      = state_q;

endmodule

// File: tb/tb_timer_controller.sv
module tb_timer_controller;
  localparam int P = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, load_valid, load_mode, start, stop, hold;
  logic [W-1:0] load_count;
  logic         load_ready, expire, busy;
  logic [W-1:0] remaining;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_controller #(.PRESCALE(P), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_count (load_count),
    .load_mode  (load_mode),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .expire     (expire),
    .busy       (busy),
    .remaining  (remaining),
    .state      (state)
  );

  typedef struct {
    logic         rs, lv;
    logic [W-1:0] lc;
    logic         lm, st, sp, hd;
    int           n;
    int           npulse;
    logic [1:0]   e_state;
    logic         e_busy, e_exp, e_ready;
    logic [W-1:0] e_rem;
  } vec_t;

  vec_t tbl[$];

  // reference model state (state uses the output encoding 0..3)
  int           m_st;
  int           m_rem, m_reload, m_phase;
  bit           m_mode, m_exp;

  task automatic drive(input logic rs, lv, input logic [W-1:0] lc,
                       input logic lm, st, sp, hd);
    reset = rs; load_valid = lv; load_count = lc; load_mode = lm;
    start = st; stop = sp; hold = hd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic rs, lv, input int lc, input logic lm, st, sp, hd,
                              input int n, np, input int es, input logic eb, ee, er,
                              input int erem);
    vec_t v;
    v.rs = rs; v.lv = lv; v.lc = W'(lc); v.lm = lm; v.st = st; v.sp = sp; v.hd = hd;
    v.n = n; v.npulse = np; v.e_state = 2'(es); v.e_busy = eb; v.e_exp = ee;
    v.e_ready = er; v.e_rem = W'(erem);
    return v;
  endfunction

  // One clock of the behavioural model: counts elapsed cycles in the current
  // base period upward and fires the tick on the P-th counted cycle.
  task automatic model_step(input logic rs, lv, input logic [W-1:0] lc,
                            input logic lm, st, sp, hd);
    m_exp = 0;
    if (rs) begin
      m_st = 0; m_rem = 0; m_reload = 0; m_mode = 0; m_phase = 0;
    end else if (m_st == 0 || m_st == 3) begin
      if (lv) begin
        m_reload = int'(lc); m_mode = lm; m_rem = int'(lc); m_st = 0;
      end else if (st && m_reload != 0) begin
        m_rem = m_reload; m_phase = 0; m_st = 1;
      end
    end else if (sp) begin
      m_st = 0; m_rem = m_reload; m_phase = 0;
    end else if (m_st == 2) begin
      if (!hd) m_st = 1;
    end else if (hd) begin
      m_st = 2;
      if (m_phase < P - 1) m_phase++;
    end else if (m_phase == P - 1) begin
      m_phase = 0;
      if (m_rem > 1) m_rem--;
      else begin
        m_exp = 1;
        if (m_mode) m_rem = m_reload;
        else begin m_rem = 0; m_st = 3; end
      end
    end else begin
      m_phase++;
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    next_cycle();
  endtask

  task automatic do_load(input int lc, input logic lm);
    drive(0, 1, W'(lc), lm, 0, 0, 0);
    next_cycle();
  endtask

  initial begin
    int pulses;
    int exp_cyc[$];
    int hold_cyc[$];
    bit run_ok;

    drive(0, 0, 0, 0, 0, 0, 0);

    // rs lv lc lm st sp hd | n np | state busy exp ready rem
    tbl.push_back(mk(1,0,0,0,0,0,0, 1,0, 0,0,0,1,0));  // reset values
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0, 0,0,0,1,3));  // load 3 one-shot
    tbl.push_back(mk(0,0,0,0,1,0,0, 1,0, 1,1,0,0,3));  // start -> RUN in cycle 1
    tbl.push_back(mk(0,0,0,0,0,0,0, 4,0, 1,1,0,0,2));  // cycle 5
    tbl.push_back(mk(0,0,0,0,0,0,0, 7,0, 1,1,0,0,1));  // cycle 12
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0, 3,0,1,1,0));  // cycle 13 expire, DONE
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1, 3,0,0,1,0));  // cycle 14 single pulse
    tbl.push_back(mk(0,1,1,1,0,0,0, 1,0, 0,0,0,1,1));  // load in DONE -> IDLE
    tbl.push_back(mk(0,0,0,0,1,0,0, 1,0, 1,1,0,0,1));  // start
    tbl.push_back(mk(0,0,0,0,0,0,0, 3,0, 1,1,0,0,1));  // cycle 4
    tbl.push_back(mk(0,0,0,0,0,1,0, 1,0, 0,0,0,1,1));  // stop on tick: IDLE, no expire
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,0, 0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,1,0,0, 1,0, 1,1,0,0,1));  // start again
    tbl.push_back(mk(0,1,5,0,0,0,0, 2,0, 1,1,0,0,1));  // load during RUN ignored
    tbl.push_back(mk(0,0,0,0,0,1,0, 1,0, 0,0,0,1,1));  // stop: remaining = old reload
    tbl.push_back(mk(0,1,0,0,0,0,0, 1,0, 0,0,0,1,0));  // load 0
    tbl.push_back(mk(0,0,0,0,1,0,0, 1,0, 0,0,0,1,0));  // start with 0 ignored
    tbl.push_back(mk(0,0,0,0,0,0,0, 6,0, 0,0,0,1,0));
    tbl.push_back(mk(0,1,3,1,0,0,0, 1,0, 0,0,0,1,3));  // load 3 periodic
    tbl.push_back(mk(0,0,0,0,1,0,0, 1,0, 1,1,0,0,3));  // start
    tbl.push_back(mk(0,0,0,0,0,0,0, 5,0, 1,1,0,0,2));  // cycle 6
    tbl.push_back(mk(1,0,0,0,0,0,0, 1,0, 0,0,0,1,0));  // reset in cycle 6
    tbl.push_back(mk(0,0,0,0,1,0,0, 1,0, 0,0,0,1,0));  // start with no load ignored
    tbl.push_back(mk(0,0,0,0,0,0,0, 4,0, 0,0,0,1,0));

    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].lv, tbl[i].lc, tbl[i].lm, tbl[i].st, tbl[i].sp, tbl[i].hd);
      pulses = 0;
      repeat (tbl[i].n) begin
        if (expire === 1'b1) pulses++;
        next_cycle();
      end
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_expire", i), 32'(expire), 32'(tbl[i].e_exp));
      check($sformatf("tbl%0d_ready", i), 32'(load_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_rem", i), 32'(remaining), 32'(tbl[i].e_rem));
      check($sformatf("tbl%0d_pulses", i), 32'(pulses), 32'(tbl[i].npulse));
    end

    // periodic 2: expiries at 9, 17, 25, remaining back to 2, always RUN
    do_reset();
    do_load(2, 1);
    exp_cyc.delete();
    run_ok = 1;
    for (int c = 0; c <= 27; c++) begin
      drive(0, 0, 0, 0, c == 0, 0, 0);
      if (c >= 1) begin
        if (state !== 2'b01) run_ok = 0;
        if (expire === 1'b1) begin
          exp_cyc.push_back(c);
          check("per_rem", 32'(remaining), 32'd2);
        end
      end
      next_cycle();
    end
    check("per_run", 32'(run_ok), 32'd1);
    check("per_count", 32'(exp_cyc.size()), 32'd3);
    foreach (exp_cyc[i]) check($sformatf("per_cyc%0d", i), 32'(exp_cyc[i]), 32'(9 + 8 * i));

    // one-shot 3 with hold in cycles 3..7: HOLD in 4..8, expire in 18
    do_reset();
    do_load(3, 0);
    exp_cyc.delete();
    hold_cyc.delete();
    for (int c = 0; c <= 22; c++) begin
      drive(0, 0, 0, 0, c == 0, 0, (c >= 3) && (c <= 7));
      if (state === 2'b10) hold_cyc.push_back(c);
      if (expire === 1'b1) exp_cyc.push_back(c);
      next_cycle();
    end
    check("hold_len", 32'(hold_cyc.size()), 32'd5);
    foreach (hold_cyc[i]) check($sformatf("hold_cyc%0d", i), 32'(hold_cyc[i]), 32'(4 + i));
    check("hold_exp_count", 32'(exp_cyc.size()), 32'd1);
    foreach (exp_cyc[i]) check("hold_exp_cyc", 32'(exp_cyc[i]), 32'd18);
    check("hold_done", 32'(state), 32'd3);

    // hold on the tick cycle: tick waits for the first RUN cycle after release
    do_reset();
    do_load(1, 1);
    exp_cyc.delete();
    hold_cyc.delete();
    for (int c = 0; c <= 12; c++) begin
      drive(0, 0, 0, 0, c == 0, 0, c == 4);
      if (state === 2'b10) hold_cyc.push_back(c);
      if (expire === 1'b1) exp_cyc.push_back(c);
      next_cycle();
    end
    check("defer_hold_len", 32'(hold_cyc.size()), 32'd1);
    foreach (hold_cyc[i]) check("defer_hold_cyc", 32'(hold_cyc[i]), 32'd5);
    check("defer_exp_count", 32'(exp_cyc.size()), 32'd2);
    foreach (exp_cyc[i]) check($sformatf("defer_exp%0d", i), 32'(exp_cyc[i]), 32'(7 + 4 * i));

    // randomized traffic against the behavioural model
    for (int k = 0; k < 4000; k++) begin
      logic rs, lv, lm, st, sp, hd;
      logic [W-1:0] lc;
      logic [12:0] act, req;
      rs = (k == 0) || ($urandom_range(199) == 0);
      lv = ($urandom_range(99) < 15);
      lc = W'($urandom_range(4));
      lm = 1'($urandom_range(1));
      st = ($urandom_range(99) < 20);
      sp = ($urandom_range(99) < 3);
      hd = ($urandom_range(99) < 12);
      if (k > 0) begin
        act = {state, busy, expire, load_ready, remaining};
        req = {2'(m_st), (m_st == 1 || m_st == 2), m_exp, (m_st == 0 || m_st == 3), W'(m_rem)};
        check($sformatf("rand%0d", k), 32'(act), 32'(req));
      end
      drive(rs, lv, lc, lm, st, sp, hd);
      model_step(rs, lv, lc, lm, st, sp, hd);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
